// File: rtl/clock_set_controller_if.sv
// Button/strobe bundle between the clock-set controller and its surroundings.
interface clock_set_controller_if;
    logic i_tick_stb;
    logic i_btn_hours;
    logic i_btn_minutes;
    logic o_set_hours;
    logic o_set_minutes;
    logic o_set_stb;

    modport master (
        output i_tick_stb,
        output i_btn_hours,
        output i_btn_minutes,
        input  o_set_hours,
        input  o_set_minutes,
        input  o_set_stb
    );

    modport slave (
        input  i_tick_stb,
        input  i_btn_hours,
        input  i_btn_minutes,
        output o_set_hours,
        output o_set_minutes,
        output o_set_stb
    );
endinterface

// File: rtl/clock_set_controller.sv
// Clock-set button controller: press strobe, hold-delay, optional auto-repeat, both-button clear.
// Auto-repeat is built only when CLOCK_SET_AUTO_REPEAT_EN is defined.
//
// state   | meaning
// IDLE    | no button held, outputs low
// DELAY   | one button held, waiting DELAY_TICKS before repeating
// REPEAT  | one button held, strobing every REPEAT_TICKS
// BOTH    | both buttons held, both selects high (seconds clear)
// RELEASE | after a clear, wait for both buttons released
module clock_set_controller #(
    parameter int DELAY_TICKS  = 16,
    parameter int REPEAT_TICKS = 4,
    parameter int CNT_W        = 5
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    clock_set_controller_if.slave bus
);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DELAY   = 3'd1,
        REPEAT  = 3'd2,
        BOTH    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sel_hours, sel_nxt;
    logic             set_hours_q, set_minutes_q, set_stb_q;
    logic             hours_nxt, minutes_nxt, stb_nxt;
    logic             sel_btn, other_btn, terminal;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            sel_hours     <= 1'b0;
            set_hours_q   <= 1'b0;
            set_minutes_q <= 1'b0;
            set_stb_q     <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            sel_hours     <= sel_nxt;
            set_hours_q   <= hours_nxt;
            set_minutes_q <= minutes_nxt;
            set_stb_q     <= stb_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sel_nxt     = sel_hours;
        hours_nxt   = 1'b0;
        minutes_nxt = 1'b0;
        stb_nxt     = 1'b0;
        sel_btn     = sel_hours ? bus.i_btn_hours   : bus.i_btn_minutes;
        other_btn   = sel_hours ? bus.i_btn_minutes : bus.i_btn_hours;
        terminal    = (state == DELAY) ? (cnt >= DELAY_TC) : (cnt >= REPEAT_TC);

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.i_btn_hours && bus.i_btn_minutes) begin
                    state_nxt   = BOTH;
                    hours_nxt   = 1'b1;
                    minutes_nxt = 1'b1;
                end else if (bus.i_btn_hours || bus.i_btn_minutes) begin
                    state_nxt   = DELAY;
                    sel_nxt     = bus.i_btn_hours;
                    hours_nxt   = bus.i_btn_hours;
                    minutes_nxt = bus.i_btn_minutes;
                    stb_nxt     = 1'b1;
                end
            end
            DELAY, REPEAT: begin
                if (!sel_btn) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (other_btn) begin
                    state_nxt   = BOTH;
                    cnt_nxt     = '0;
                    hours_nxt   = 1'b1;
                    minutes_nxt = 1'b1;
                end else begin
                    hours_nxt   = sel_hours;
                    minutes_nxt = !sel_hours;
                    if (bus.i_tick_stb) begin
                        // Terminal count saturates; a strobe is deferred if one just fired.
                        if (terminal) begin
                            if (AUTO_REPEAT && !set_stb_q) begin
                                stb_nxt   = 1'b1;
                                cnt_nxt   = '0;
                                state_nxt = REPEAT;
                            end
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
            end
            BOTH: begin
                cnt_nxt = '0;
                if (!bus.i_btn_hours && !bus.i_btn_minutes) begin
                    state_nxt = IDLE;
                end else if (bus.i_btn_hours ^ bus.i_btn_minutes) begin
                    state_nxt = RELEASE;
                end else begin
                    hours_nxt   = 1'b1;
                    minutes_nxt = 1'b1;
                end
            end
            RELEASE: begin
                cnt_nxt = '0;
                if (!bus.i_btn_hours && !bus.i_btn_minutes) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.o_set_hours   = set_hours_q;
    assign bus.o_set_minutes = set_minutes_q;
    assign bus.o_set_stb     = set_stb_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller; expectations follow CLOCK_SET_AUTO_REPEAT_EN.
module tb_clock_set_controller;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   total_stb;
    int   viol;
    logic prev_stb;
    int   base;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int HOLD24_STB = 4;
`else
    localparam int HOLD24_STB = 1;
`endif

    clock_set_controller_if bus ();

    clock_set_controller #(
        .DELAY_TICKS (16),
        .REPEAT_TICKS(4),
        .CNT_W       (5)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counter and output invariants, sampled just after each edge.
    initial begin
        total_stb = 0;
        viol      = 0;
        prev_stb  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_set_stb) begin
                total_stb++;
                if (!(bus.o_set_hours ^ bus.o_set_minutes)) viol++;
                if (prev_stb) viol++;
            end
            prev_stb = bus.o_set_stb;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (7) @(negedge clk);
            bus.i_tick_stb = 1'b1;
            @(negedge clk);
            bus.i_tick_stb = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.i_tick_stb    = 1'b0;
        bus.i_btn_hours   = 1'b0;
        bus.i_btn_minutes = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hours", int'(bus.o_set_hours), 0);
        check("rst_minutes", int'(bus.o_set_minutes), 0);
        check("rst_stb", int'(bus.o_set_stb), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Short hours press
        base = total_stb;
        bus.i_btn_hours = 1'b1;
        @(negedge clk);
        check("press_hours_sel", int'(bus.o_set_hours), 1);
        check("press_minutes_sel", int'(bus.o_set_minutes), 0);
        check("press_stb", int'(bus.o_set_stb), 1);
        @(negedge clk);
        check("press_stb_single", int'(bus.o_set_stb), 0);
        run_ticks(3);
        bus.i_btn_hours = 1'b0;
        repeat (2) @(negedge clk);
        check("short_press_count", total_stb - base, 1);
        check("short_idle_hours", int'(bus.o_set_hours), 0);

        // Held without ticks: the delay must not advance
        base = total_stb;
        bus.i_btn_hours = 1'b1;
        repeat (200) @(negedge clk);
        check("no_tick_count", total_stb - base, 1);
        bus.i_btn_hours = 1'b0;
        repeat (2) @(negedge clk);

        // Minutes held 24 ticks
        base = total_stb;
        bus.i_btn_minutes = 1'b1;
        run_ticks(24);
        check("hold24_minutes_sel", int'(bus.o_set_minutes), 1);
        bus.i_btn_minutes = 1'b0;
        repeat (2) @(negedge clk);
        check("hold24_count", total_stb - base, HOLD24_STB);
        check("hold24_idle_minutes", int'(bus.o_set_minutes), 0);

        // Both pressed, hours released first
        base = total_stb;
        bus.i_btn_hours   = 1'b1;
        bus.i_btn_minutes = 1'b1;
        @(negedge clk);
        check("both_hours", int'(bus.o_set_hours), 1);
        check("both_minutes", int'(bus.o_set_minutes), 1);
        check("both_stb", int'(bus.o_set_stb), 0);
        bus.i_btn_hours = 1'b0;
        run_ticks(5);
        check("release_hours", int'(bus.o_set_hours), 0);
        check("release_minutes", int'(bus.o_set_minutes), 0);
        bus.i_btn_minutes = 1'b0;
        repeat (2) @(negedge clk);
        check("clear_count", total_stb - base, 0);
        bus.i_btn_minutes = 1'b1;
        @(negedge clk);
        check("after_clear_stb", int'(bus.o_set_stb), 1);
        bus.i_btn_minutes = 1'b0;
        repeat (2) @(negedge clk);
        check("after_clear_count", total_stb - base, 1);

        // Hours added while minutes held
        base = total_stb;
        bus.i_btn_minutes = 1'b1;
        run_ticks(5);
        bus.i_btn_hours = 1'b1;
        @(negedge clk);
        check("join_hours", int'(bus.o_set_hours), 1);
        check("join_minutes", int'(bus.o_set_minutes), 1);
        run_ticks(12);
        check("join_count", total_stb - base, 1);
        bus.i_btn_hours   = 1'b0;
        bus.i_btn_minutes = 1'b0;
        repeat (2) @(negedge clk);
        check("join_idle_hours", int'(bus.o_set_hours), 0);

        // Release coincident with the 16th tick
        base = total_stb;
        bus.i_btn_hours = 1'b1;
        run_ticks(15);
        repeat (7) @(negedge clk);
        bus.i_tick_stb  = 1'b1;
        bus.i_btn_hours = 1'b0;
        @(negedge clk);
        bus.i_tick_stb = 1'b0;
        @(negedge clk);
        check("coincident_count", total_stb - base, 1);
        check("coincident_hours", int'(bus.o_set_hours), 0);

        // Asynchronous reset while holding minutes
        bus.i_btn_minutes = 1'b1;
        run_ticks(18);
        repeat (3) @(negedge clk);
        check("pre_reset_minutes", int'(bus.o_set_minutes), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_hours", int'(bus.o_set_hours), 0);
        check("async_minutes", int'(bus.o_set_minutes), 0);
        check("async_stb", int'(bus.o_set_stb), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("repress_stb", int'(bus.o_set_stb), 1);
        check("repress_minutes", int'(bus.o_set_minutes), 1);
        bus.i_btn_minutes = 1'b0;
        repeat (2) @(negedge clk);

        check("invariants", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 SHALL have parameter DELAY_TICKS, default 16: i_tick_stb pulses held before auto-repeat starts (range 2..2^CNT_W-1).
REQ-002 SHALL have parameter REPEAT_TICKS, default 4: i_tick_stb pulses between auto-repeat strobes (range 1..2^CNT_W-1).
REQ-003 SHALL have parameter CNT_W, default 5: tick counter width.
REQ-004 SHALL have port i_clk input 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset_n input 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_tick_stb input 1: single-cycle timebase strobe.
REQ-007 SHALL have port i_btn_hours input 1: debounced, synchronized level, high = pressed.
REQ-008 SHALL have port i_btn_minutes input 1: debounced, synchronized level, high = pressed.
REQ-009 SHALL have port o_set_hours output 1: registered hours-select to the time register.
REQ-010 SHALL have port o_set_minutes output 1: registered minutes-select to the time register.
REQ-011 SHALL have port o_set_stb output 1: registered single-cycle increment strobe to the time register.

Function
REQ-012 SHALL implement FSM states IDLE, DELAY, REPEAT, BOTH, RELEASE.
REQ-013 IDLE, exactly one button high: next edge -> DELAY; select latched; matching o_set_* high; o_set_stb high one cycle; counter cleared.
REQ-014 IDLE, both buttons high on the same cycle: -> BOTH, no strobe.
REQ-015 DELAY: counter increments only on i_tick_stb; tick at count DELAY_TICKS-1 -> strobe, counter cleared, -> REPEAT.
REQ-016 REPEAT: tick at count REPEAT_TICKS-1 -> strobe, counter cleared, stay in REPEAT.
REQ-017 DELAY/REPEAT, selected button released: -> IDLE, outputs low; release wins over a coincident tick (no strobe).
REQ-018 DELAY/REPEAT, other button becomes high while selected one held: -> BOTH, no strobe on that cycle.
REQ-019 BOTH: o_set_hours and o_set_minutes both high (seconds clear), o_set_stb never high.
REQ-020 BOTH, exactly one button released: -> RELEASE; both released same cycle: -> IDLE.
REQ-021 RELEASE: all outputs low; stay until both buttons low, then -> IDLE (no increment after a clear).
REQ-022 o_set_stb SHALL only be high on cycles where exactly one o_set_* is high; never on consecutive cycles.
REQ-023 o_set_hours and o_set_minutes SHALL both be low in IDLE and RELEASE.
REQ-024 Counter SHALL never wrap; compare with >= so out-of-range values resolve as terminal.

Reset
REQ-025 i_reset_n low SHALL asynchronously force state IDLE, counter 0, o_set_hours 0, o_set_minutes 0, o_set_stb 0.
REQ-026 Reset asserted mid-DELAY/REPEAT/BOTH SHALL abort with no further strobe; after release, a still-held button is treated as a new press from IDLE.

Configuration
REQ-027 Macro CLOCK_SET_AUTO_REPEAT_EN defined: REPEAT state and REQ-015/REQ-016 strobes present.
REQ-028 Macro CLOCK_SET_AUTO_REPEAT_EN undefined: DELAY holds select without strobes until release (one strobe per press); REPEAT unreachable; REQ-017/REQ-018 apply unchanged.

Verification (DELAY_TICKS=16, REPEAT_TICKS=4, tick every 8 clks)
REQ-029 Hours pressed for 3 ticks -> exactly 1 o_set_stb with o_set_hours=1, o_set_minutes=0; then IDLE, outputs 0.
REQ-030 Minutes held 24 ticks, macro defined -> 4 strobes (press, tick 16, 20, 24); macro undefined -> 1 strobe.
REQ-031 Both pressed together, hours released first, minutes released 5 ticks later -> both selects high during BOTH, 0 strobes, outputs low in RELEASE; next minutes press -> 1 strobe.
REQ-032 Minutes held, hours added at tick 5 -> BOTH on next edge, no strobe at tick 16.
REQ-033 Release coincident with the 16th tick -> 0 strobes beyond the initial one.
REQ-034 i_reset_n pulsed low mid-REPEAT -> all outputs 0 immediately (async); held button after reset release -> new initial strobe one edge later.
